mrd_tag_pool_arbiter: RTL

//  Shared MRd tag allocator for all S2C scatter-gather channels. Round-robin arbitrates the channels'

---
 rtl/mrd_tag_pool_arbiter_if.sv | 31 +++
 rtl/mrd_tag_pool_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mrd_tag_pool_arbiter_if.sv
// Bundle of request, grant, retire and status signals between the S2C channels,
// the completion router and the shared MRd tag pool arbiter.
interface mrd_tag_pool_arbiter_if #(
  parameter int NUM_CHAN  = 4,
  parameter int NUM_TAGS  = 32,
  parameter int TAG_WIDTH = 8,
  parameter int CNT_W     = $clog2(NUM_TAGS + 1)
);
  logic [NUM_CHAN-1:0]  alloc_tag_req;
  logic [NUM_CHAN-1:0]  allocated_tag_rdy;
  logic [TAG_WIDTH-1:0] allocated_tag;
  logic                 tag_free_valid;
  logic [TAG_WIDTH-1:0] tag_free_tag;
  logic                 err_clr;
  logic [CNT_W-1:0]     tags_in_use;
  logic                 pool_empty;
  logic                 err_double_free;
  logic                 err_bad_tag;

  modport master (
    output alloc_tag_req, tag_free_valid, tag_free_tag, err_clr,
    input  allocated_tag_rdy, allocated_tag, tags_in_use, pool_empty,
           err_double_free, err_bad_tag
  );

  modport slave (
    input  alloc_tag_req, tag_free_valid, tag_free_tag, err_clr,
    output allocated_tag_rdy, allocated_tag, tags_in_use, pool_empty,
           err_double_free, err_bad_tag
  );
endinterface

// File: rtl/mrd_tag_pool_arbiter.sv
// Shared MRd tag allocator: round-robin grants free read tags to S2C channels and
// reclaims them on retire, so no tag is ever outstanding twice.
module mrd_tag_pool_arbiter #(
  parameter int NUM_CHAN  = 4,
  parameter int NUM_TAGS  = 32,
  parameter int TAG_WIDTH = 8,
  parameter int CNT_W     = $clog2(NUM_TAGS + 1)
) (
  input logic                   s_axi_clk,
  input logic                   s_axi_rstn,
  mrd_tag_pool_arbiter_if.slave bus
);

  localparam int PTR_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int TIDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam logic [TAG_WIDTH:0] TAG_LIMIT = (TAG_WIDTH + 1)'(NUM_TAGS);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(NUM_TAGS);

  logic [NUM_TAGS-1:0]  in_use;
  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_CHAN-1:0]  rdy_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [CNT_W-1:0]     count_q;
  logic                 err_df_q;
  logic                 err_bad_q;

  logic [NUM_CHAN-1:0]  eligible;
  logic [PTR_W-1:0]     cand;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     rr_ptr_next;
  logic                 winner_found;
  logic                 grant;
  logic [TAG_WIDTH-1:0] free_tag;
  logic [NUM_TAGS-1:0]  alloc_mask;
  logic [NUM_TAGS-1:0]  free_mask;
  logic [NUM_TAGS-1:0]  in_use_next;
  logic                 free_any;
  logic                 bad_tag;
  logic                 double_free;
  logic [CNT_W-1:0]     count_next;

  // rdy_q doubles as the last-grant mask, hiding a channel's req-drop latency.
  always_comb begin
    eligible     = bus.alloc_tag_req & ~rdy_q;
    cand         = '0;
    winner       = '0;
    winner_found = 1'b0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_CHAN);
      if (eligible[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
    rr_ptr_next = PTR_W'((int'(winner) + 1) % NUM_CHAN);

    free_tag = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!in_use[TIDX_W'(t)]) free_tag = TAG_WIDTH'(t);
    end
    grant = winner_found && !(&in_use);
  end

  // Retire only clears a bit that is set, so the grant tag can never be freed in the same cycle.
  always_comb begin
    free_mask = '0;
    bad_tag   = bus.tag_free_valid && ({1'b0, bus.tag_free_tag} >= TAG_LIMIT);
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (bus.tag_free_valid && (bus.tag_free_tag == TAG_WIDTH'(t)) && in_use[TIDX_W'(t)])
        free_mask[TIDX_W'(t)] = 1'b1;
    end
    free_any    = |free_mask;
    double_free = bus.tag_free_valid && !bad_tag && !free_any;

    alloc_mask = '0;
    if (grant) alloc_mask[TIDX_W'(free_tag)] = 1'b1;
    in_use_next = (in_use | alloc_mask) & ~free_mask;

    count_next = count_q;
    if (grant && !free_any)      count_next = count_q + CNT_W'(1);
    else if (!grant && free_any) count_next = count_q - CNT_W'(1);
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
    if (!s_axi_rstn) begin
      in_use    <= '0;
      rr_ptr    <= '0;
      rdy_q     <= '0;
      tag_q     <= '0;
      count_q   <= '0;
      err_df_q  <= 1'b0;
      err_bad_q <= 1'b0;
    end else begin
      in_use  <= in_use_next;
      count_q <= count_next;
      if (grant) begin
        rr_ptr <= rr_ptr_next;
        rdy_q  <= NUM_CHAN'(1) << winner;
        tag_q  <= free_tag;
      end else begin
        rdy_q  <= '0;
        tag_q  <= '0;
      end
      // A fresh error outranks a simultaneous clear.
      if (double_free)      err_df_q <= 1'b1;
      else if (bus.err_clr) err_df_q <= 1'b0;
      if (bad_tag)          err_bad_q <= 1'b1;
      else if (bus.err_clr) err_bad_q <= 1'b0;
    end
  end

  assign bus.allocated_tag_rdy = rdy_q;
  assign bus.allocated_tag     = tag_q;
  assign bus.tags_in_use       = count_q;
  assign bus.pool_empty        = (count_q == CNT_FULL);
  assign bus.err_double_free   = err_df_q;
  assign bus.err_bad_tag       = err_bad_q;

endmodule
